// File: rtl/sdram_port_arb.sv
// rtl/sdram_port_arb.sv - round-robin multi-port front-end arbiter for the SDRAM write/read command path
//
// Ports:
//   sclk, srst_n          clock, asynchronous active-low reset
//   init_end              SDRAM init complete; requests ignored until high
//   port_req/we/addr/len  per-port burst request, direction and descriptor (packed)
//   port_gnt/done/err     one-hot single-cycle grant, completion and ack-timeout pulses
//   cur_port, busy        owner of the current burst, FSM not idle
//   wr_req/rd_req         burst request toward the SDRAM arbiter, held until ack
//   sd_addr/sd_len        descriptor latched at grant
//   wr_ack/rd_ack         request accepted pulses
//   wr_done/rd_done       burst finished pulses
module sdram_port_arb #(
    parameter int NPORT   = 4,
    parameter int ADDR_W  = 24,
    parameter int LEN_W   = 9,
    parameter int ACK_TMO = 1023
) (
    input  logic                      sclk,
    input  logic                      srst_n,
    input  logic                      init_end,
    input  logic [NPORT-1:0]          port_req,
    input  logic [NPORT-1:0]          port_we,
    input  logic [NPORT*ADDR_W-1:0]   port_addr,
    input  logic [NPORT*LEN_W-1:0]    port_len,
    output logic [NPORT-1:0]          port_gnt,
    output logic [NPORT-1:0]          port_done,
    output logic [NPORT-1:0]          port_err,
    output logic [$clog2(NPORT)-1:0]  cur_port,
    output logic                      busy,
    output logic                      wr_req,
    output logic                      rd_req,
    output logic [ADDR_W-1:0]         sd_addr,
    output logic [LEN_W-1:0]          sd_len,
    input  logic                      wr_ack,
    input  logic                      rd_ack,
    input  logic                      wr_done,
    input  logic                      rd_done
);
    localparam int PW = $clog2(NPORT);
    localparam int CW = $clog2(ACK_TMO + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [PW-1:0]       cur_q, cur_d;
    logic                dir_q, dir_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NPORT-1:0]    gnt_q, gnt_d;
    logic [NPORT-1:0]    done_q, done_d;
    logic [NPORT-1:0]    err_q, err_d;
    logic                wr_req_q, wr_req_d;
    logic                rd_req_q, rd_req_d;
    logic                busy_q, busy_d;

    logic [ADDR_W-1:0]   addr_arr [NPORT];
    logic [LEN_W-1:0]    len_arr  [NPORT];
    logic                found;
    logic [PW-1:0]       sel;
    logic                ack_m;
    logic                done_m;

    for (genvar g = 0; g < NPORT; g++) begin : g_unpack
        assign addr_arr[g] = port_addr[g*ADDR_W +: ADDR_W];
        assign len_arr[g]  = port_len[g*LEN_W +: LEN_W];
    end

    // First requester after the last owner, wrapping modulo NPORT.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = 1; k <= NPORT; k++) begin
            if (!found && port_req[PW'((int'(ptr_q) + k) % NPORT)]) begin
                found = 1'b1;
                sel   = PW'((int'(ptr_q) + k) % NPORT);
            end
        end
    end

    // Only the ack/done matching the latched direction counts.
    assign ack_m  = dir_q ? wr_ack  : rd_ack;
    assign done_m = dir_q ? wr_done : rd_done;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cur_d    = cur_q;
        dir_d    = dir_q;
        addr_d   = addr_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        gnt_d    = '0;
        done_d   = '0;
        err_d    = '0;
        wr_req_d = 1'b0;
        rd_req_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (init_end && found) begin
                    gnt_d[sel] = 1'b1;
                    cur_d      = sel;
                    dir_d      = port_we[sel];
                    addr_d     = addr_arr[sel];
                    len_d      = len_arr[sel];
                    wr_req_d   = port_we[sel];
                    rd_req_d   = !port_we[sel];
                    // Counts the ISSUE cycle being entered.
                    cnt_d      = CW'(1);
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (ack_m) begin
                    if (done_m) begin
                        done_d[cur_q] = 1'b1;
                        ptr_d         = cur_q;
                        state_d       = IDLE;
                    end else begin
                        state_d = BUSY;
                    end
                end else if (cnt_q == CW'(ACK_TMO)) begin
                    err_d[cur_q] = 1'b1;
                    ptr_d        = cur_q;
                    state_d      = IDLE;
                end else begin
                    wr_req_d = dir_q;
                    rd_req_d = !dir_q;
                    cnt_d    = cnt_q + 1'b1;
                end
            end
            BUSY: begin
                // No timeout here: refresh may legally stall the burst.
                if (done_m) begin
                    done_d[cur_q] = 1'b1;
                    ptr_d         = cur_q;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            state_q  <= IDLE;
            ptr_q    <= PW'(NPORT - 1);
            cur_q    <= '0;
            dir_q    <= 1'b0;
            addr_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            err_q    <= '0;
            wr_req_q <= 1'b0;
            rd_req_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cur_q    <= cur_d;
            dir_q    <= dir_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
            wr_req_q <= wr_req_d;
            rd_req_q <= rd_req_d;
            busy_q   <= busy_d;
        end
    end

    assign port_gnt  = gnt_q;
    assign port_done = done_q;
    assign port_err  = err_q;
    assign cur_port  = cur_q;
    assign busy      = busy_q;
    assign wr_req    = wr_req_q;
    assign rd_req    = rd_req_q;
    assign sd_addr   = addr_q;
    assign sd_len    = len_q;

endmodule
